// File: rtl/sha256_msg_loader.sv
// sha256_msg_loader: streams a single-block message into a sha256 core, pads it, starts it and streams the digest out
module sha256_msg_loader #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    input  logic       m_ready,
    output logic [6:0] o_w_addr,
    output logic [7:0] o_data8,
    output logic       o_we,
    input  logic [7:0] i_core_data,
    input  logic       i_core_irq,
    output logic       o_busy,
    output logic       o_err
);
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [3:0] {CLR0, IDLE, LOAD, PAD, START, WAIT, READ, CLR, DRAIN} state_t;

    state_t        state, state_n;
    logic [5:0]    cnt, len, idx;
    logic [4:0]    rd_idx;
    logic [TW-1:0] timer;
    logic          acc, hs, we_n, err_set, err_clr;
    logic [6:0]    addr_n;
    logic [7:0]    data_n, pad_byte;

    assign s_ready  = state inside {IDLE, LOAD, DRAIN};
    assign o_busy   = state != IDLE;
    assign acc      = s_valid & s_ready;
    assign hs       = (state == READ) & m_valid & m_ready;
    assign idx      = (state == IDLE) ? 6'd0 : cnt;
    // Padding byte for index cnt: 0x80 marker, zero fill, then the low two bytes of the bit length L*8 (L <= 55)
    assign pad_byte = (cnt == len)   ? 8'h80 :
                      (cnt == 6'd63) ? {len[4:0], 3'b000} :
                      (cnt == 6'd62) ? {7'd0, len[5]} : 8'h00;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= CLR0;
        else       state <= state_n;
    end

    // Next state and the next core write (core write port is registered)
    always_comb begin
        state_n = state;
        we_n    = 1'b0;
        addr_n  = o_w_addr;
        data_n  = o_data8;
        err_set = 1'b0;
        err_clr = 1'b0;
        case (state)
            CLR0, CLR: begin
                we_n    = 1'b1;
                addr_n  = 7'd65;
                data_n  = 8'h00;
                state_n = IDLE;
            end
            IDLE, LOAD: if (acc) begin
                err_clr = state == IDLE;
                if (idx == 6'd55) begin
                    err_set = 1'b1;
                    state_n = s_last ? CLR : DRAIN;
                end else begin
                    we_n    = 1'b1;
                    addr_n  = 7'd63 - {1'b0, idx};
                    data_n  = s_data;
                    state_n = s_last ? PAD : LOAD;
                end
            end
            PAD: begin
                we_n    = 1'b1;
                addr_n  = 7'd63 - {1'b0, cnt};
                data_n  = pad_byte;
                state_n = (cnt == 6'd63) ? START : PAD;
            end
            START: begin
                we_n    = 1'b1;
                addr_n  = 7'd65;
                data_n  = 8'h01;
                state_n = WAIT;
            end
            WAIT: begin
                if (i_core_irq) begin
                    addr_n  = 7'd101;
                    state_n = READ;
                end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_set = 1'b1;
                    state_n = CLR;
                end
            end
            READ: if (hs) begin
                addr_n  = 7'd100 - {2'b0, rd_idx};
                state_n = m_last ? CLR : READ;
            end
            DRAIN: state_n = (acc && s_last) ? CLR : DRAIN;
            default: state_n = CLR0;
        endcase
    end

    // Datapath: core write port, counters, digest output register and error flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_we     <= 1'b0;
            o_w_addr <= 7'd0;
            o_data8  <= 8'h00;
            cnt      <= 6'd0;
            len      <= 6'd0;
            timer    <= '0;
            rd_idx   <= 5'd0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_data   <= 8'h00;
            o_err    <= 1'b0;
        end else begin
            o_we     <= we_n;
            o_w_addr <= addr_n;
            o_data8  <= data_n;
            if ((state == IDLE || state == LOAD) && acc) begin
                cnt <= idx + 6'd1;
                len <= idx + 6'd1;
            end else if (state == PAD) begin
                cnt <= cnt + 6'd1;
            end
            timer <= (state == WAIT) ? timer + 1'b1 : '0;
            if (state != READ) begin
                rd_idx  <= 5'd0;
                m_valid <= 1'b0;
                m_last  <= 1'b0;
            end else if (!m_valid) begin
                m_valid <= 1'b1;
                m_data  <= i_core_data;
                m_last  <= rd_idx == 5'd31;
            end else if (m_ready) begin
                m_valid <= 1'b0;
                m_last  <= 1'b0;
                rd_idx  <= rd_idx + 5'd1;
            end
            if (err_set)      o_err <= 1'b1;
            else if (err_clr) o_err <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sha256_msg_loader.sv
// tb_sha256_msg_loader: directed bench with a behavioural sha256 core stub
module tb_sha256_msg_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid, s_last, s_ready;
    logic [7:0] m_data;
    logic       m_valid, m_last, m_ready;
    logic [6:0] o_w_addr;
    logic [7:0] o_data8;
    logic       o_we;
    logic [7:0] core_data;
    logic       irq;
    logic       o_busy, o_err;

    int         n_vec = 0;
    int         n_bad = 0;
    logic [7:0] mem [128];
    int         wcnt [128];
    int         wsnap [128];
    int         start_cnt = 0, clr_cnt = 0, mv_cnt = 0, irq_cd = 0;
    bit         irq_en = 1'b1;
    logic [7:0] dig [32];

    localparam logic [255:0] DIG_ABC = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_A55 = 256'h9f4390f8d30c2dd92ec9f095b65e2b9ae9b0a925a5258e241c9f1e910f734318;

    always #5 clk = ~clk;

    sha256_msg_loader #(.TIMEOUT_CYCLES(64)) dut (
        .i_clk(clk), .i_rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
        .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready),
        .o_w_addr(o_w_addr), .o_data8(o_data8), .o_we(o_we),
        .i_core_data(core_data), .i_core_irq(irq),
        .o_busy(o_busy), .o_err(o_err)
    );

    assign core_data = (o_w_addr >= 7'd70 && o_w_addr <= 7'd101) ? dig[5'(7'd101 - o_w_addr)] : 8'h00;

    always @(posedge clk) begin
        if (rst) begin
            irq    <= 1'b0;
            irq_cd <= 0;
        end else begin
            if (irq_cd > 0) begin
                irq_cd <= irq_cd - 1;
                if (irq_cd == 1) irq <= 1'b1;
            end
            if (o_we) begin
                mem[o_w_addr]  <= o_data8;
                wcnt[o_w_addr] <= wcnt[o_w_addr] + 1;
                if (o_w_addr == 7'd65) begin
                    if (o_data8 == 8'h01) begin
                        start_cnt <= start_cnt + 1;
                        if (irq_en) irq_cd <= 5;
                    end else begin
                        clr_cnt <= clr_cnt + 1;
                        irq     <= 1'b0;
                    end
                end
            end
            if (m_valid) mv_cnt <= mv_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic snap();
        for (int a = 0; a < 128; a++) wsnap[a] = wcnt[a];
    endtask

    task automatic send(input logic [7:0] b, input bit last);
        int n = 0;
        s_valid = 1'b1;
        s_data  = b;
        s_last  = last;
        while (!s_ready && n < 100) begin
            tick(1);
            n++;
        end
        if (!s_ready) chk("send_ready", {63'd0, s_ready}, 64'd1);
        tick(1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_abc();
        send(8'h61, 1'b0);
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
    endtask

    task automatic wait_start(output int n);
        n = 0;
        while (!(o_we && o_w_addr == 7'd65 && o_data8 == 8'h01) && n < 300) begin
            tick(1);
            n++;
        end
        chk("start_write", {63'd0, o_we && o_w_addr == 7'd65 && o_data8 == 8'h01}, 64'd1);
    endtask

    task automatic recv(input logic [255:0] d, input bit rnd);
        int         j = 0, n = 0, stab_bad = 0, last_bad = 0;
        logic       hold = 1'b0;
        logic [7:0] held = 8'h00;
        for (int k = 0; k < 32; k++) dig[k] = d[255 - 8*k -: 8];
        while (j < 32 && n < 3000) begin
            if (hold && m_valid && m_data !== held) stab_bad++;
            m_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (m_valid && m_ready) begin
                chk("digest_byte", {56'd0, m_data}, {56'd0, dig[j]});
                if (m_last !== (j == 31)) last_bad++;
                j++;
                hold = 1'b0;
            end else if (m_valid) begin
                hold = 1'b1;
                held = m_data;
            end else begin
                hold = 1'b0;
            end
            tick(1);
            n++;
        end
        m_ready = 1'b0;
        chk("digest_count", 64'(j), 64'd32);
        chk("digest_stable", 64'(stab_bad), 64'd0);
        chk("digest_last", 64'(last_bad), 64'd0);
    endtask

    task automatic check_once(input string tag);
        int bad = 0;
        for (int a = 0; a < 64; a++) if (wcnt[a] - wsnap[a] != 1) bad++;
        chk(tag, 64'(bad), 64'd0);
    endtask

    initial begin
        int n, c0, s0, m0;
        logic [255:0] none;
        none = '0;
        rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = 8'h00; m_ready = 1'b0;
        for (int k = 0; k < 32; k++) dig[k] = none[8*k +: 8];
        tick(2);
        chk("rst_sready", {63'd0, s_ready}, 64'd0);
        chk("rst_mvalid", {63'd0, m_valid}, 64'd0);
        chk("rst_mlast", {63'd0, m_last}, 64'd0);
        chk("rst_mdata", {56'd0, m_data}, 64'd0);
        chk("rst_we", {63'd0, o_we}, 64'd0);
        chk("rst_addr", {57'd0, o_w_addr}, 64'd0);
        chk("rst_data8", {56'd0, o_data8}, 64'd0);
        chk("rst_err", {63'd0, o_err}, 64'd0);
        chk("rst_busy", {63'd0, o_busy}, 64'd1);
        @(negedge clk) rst = 1'b0;
        tick(1);
        chk("clr0_write", {o_we, o_w_addr, o_data8}, {1'b1, 7'd65, 8'h00});
        tick(1);
        chk("idle_busy", {63'd0, o_busy}, 64'd0);

        // "abc"
        snap();
        send(8'h61, 1'b0);
        chk("byte0_write", {o_we, o_w_addr, o_data8}, {1'b1, 7'd63, 8'h61});
        send(8'h62, 1'b0);
        send(8'h63, 1'b1);
        chk("abc_sready_off", {63'd0, s_ready}, 64'd0);
        recv(DIG_ABC, 1'b0);
        tick(2);
        chk("abc_block", {mem[63], mem[62], mem[61], mem[60], mem[1], mem[0]},
            {8'h61, 8'h62, 8'h63, 8'h80, 8'h00, 8'h18});
        check_once("abc_write_once");
        chk("abc_start_cnt", 64'(wcnt[65] - wsnap[65]), 64'd2);
        chk("abc_idle", {o_busy, o_err, m_valid}, 3'b000);

        // 55 x 'a', random m_ready
        snap();
        for (int i = 0; i < 55; i++) send(8'h61, i == 54);
        recv(DIG_A55, 1'b1);
        tick(2);
        chk("a55_pad", {mem[9], mem[8], mem[7], mem[1], mem[0]}, {8'h61, 8'h80, 8'h00, 8'h01, 8'hb8});
        check_once("a55_write_once");
        chk("a55_err", {63'd0, o_err}, 64'd0);

        // core never completes
        irq_en = 1'b0;
        send_abc();
        wait_start(n);
        chk("wait_sready", {63'd0, s_ready}, 64'd0);
        n = 0;
        while (!o_err && n < 300) begin
            tick(1);
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'd64);
        tick(1);
        chk("timeout_clr", {o_we, o_w_addr, o_data8, o_busy}, {1'b1, 7'd65, 8'h00, 1'b0});
        chk("timeout_err_held", {63'd0, o_err}, 64'd1);
        irq_en = 1'b1;

        // overflow: 60 bytes, s_last on the 60th
        snap();
        s0 = start_cnt;
        m0 = mv_cnt;
        send(8'h00, 1'b0);
        chk("err_cleared", {63'd0, o_err}, 64'd0);
        for (int i = 1; i < 55; i++) send(8'(i), 1'b0);
        send(8'h37, 1'b0);
        chk("ovf_err", {o_err, s_ready}, 2'b11);
        for (int i = 56; i < 60; i++) send(8'(i), i == 59);
        c0 = clr_cnt;
        tick(1);
        chk("ovf_clr", {o_we, o_w_addr, o_data8}, {1'b1, 7'd65, 8'h00});
        tick(3);
        chk("ovf_clr_cnt", 64'(clr_cnt - c0), 64'd1);
        chk("ovf_no_start", 64'(start_cnt - s0), 64'd0);
        chk("ovf_no_mvalid", 64'(mv_cnt - m0), 64'd0);
        chk("ovf_suppressed", 64'(wcnt[8] - wsnap[8]), 64'd0);
        chk("ovf_loaded", 64'(wcnt[9] - wsnap[9]), 64'd1);
        chk("ovf_idle", {o_busy, o_err}, 2'b01);

        // reset during WAIT
        irq_en = 1'b0;
        send_abc();
        wait_start(n);
        tick(3);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_outs", {s_ready, m_valid, m_last, m_data, o_we, o_w_addr, o_data8, o_err, o_busy},
            {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b0, 1'b1});
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        irq_en = 1'b1;
        tick(1);
        chk("mid_rst_clr0", {o_we, o_w_addr, o_data8}, {1'b1, 7'd65, 8'h00});
        tick(1);
        snap();
        send_abc();
        recv(DIG_ABC, 1'b1);
        tick(2);
        chk("rerun_block", {mem[63], mem[62], mem[61], mem[60], mem[0]}, {8'h61, 8'h62, 8'h63, 8'h80, 8'h18});
        check_once("rerun_write_once");
        chk("rerun_idle", {o_busy, o_err}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
